// File: rtl/varredura_matriz.sv
// varredura_matriz: front end for the 4x2 parking-spot LED matrix.
//   - conditions the 8 raw spot sensors (2-flop synchroniser + debounce)
//   - scans the two matrix columns with a blanking gap between them
//   - keeps the registered count of free spots
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   ch_in[7:0]   raw sensors, 1 = occupied (even bits column 1, odd column 2)
//   ch_out[7:0]  debounced sensors, to the column multiplexer ch0..ch7
//   sel          multiplexer column select (0 = even spots, 1 = odd spots)
//   col[1:0]     column enables, 01 = column 1, 10 = column 2, 00 = blanked
//   blank        high while both columns are off
//   frame_tick   one-cycle pulse at the start of each scan frame
//   vagas_livres free spots, 0..8
//   lotado       high when no spot is free
module varredura_matriz #(
  parameter int DIV        = 50000,
  parameter int BLANK      = 500,
  parameter int DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ch_in,
  output logic [7:0] ch_out,
  output logic       sel,
  output logic [1:0] col,
  output logic       blank,
  output logic       frame_tick,
  output logic [3:0] vagas_livres,
  output logic       lotado
);

  localparam int PMAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int PW   = $clog2(PMAX) + 1;
  localparam int DW   = $clog2(DEB_CYCLES) + 1;

  localparam logic [PW-1:0] DIV_END   = PW'(DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK - 1);
  localparam logic [DW-1:0] DEB_END   = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {S_BLANK1, S_COL0, S_BLANK0, S_COL1} state_t;

  // ---------------- scan FSM ----------------
  state_t        state_q;
  logic [PW-1:0] phase_q;
  logic          sel_q;
  logic [1:0]    col_q;
  logic          blank_q;
  logic          frame_tick_q;

  // sel only moves when entering a blank state, so the multiplexer has the
  // whole blanking interval to settle before its column lights up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_BLANK1;
      phase_q      <= '0;
      sel_q        <= 1'b0;
      col_q        <= 2'b00;
      blank_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      phase_q      <= phase_q + 1'b1;
      case (state_q)
        S_BLANK1: if (phase_q == BLANK_END) begin
          state_q      <= S_COL0;
          phase_q      <= '0;
          col_q        <= 2'b01;
          blank_q      <= 1'b0;
          frame_tick_q <= 1'b1;
        end
        S_COL0: if (phase_q == DIV_END) begin
          state_q <= S_BLANK0;
          phase_q <= '0;
          col_q   <= 2'b00;
          blank_q <= 1'b1;
          sel_q   <= 1'b1;
        end
        S_BLANK0: if (phase_q == BLANK_END) begin
          state_q <= S_COL1;
          phase_q <= '0;
          col_q   <= 2'b10;
          blank_q <= 1'b0;
        end
        default: if (phase_q == DIV_END) begin
          state_q <= S_BLANK1;
          phase_q <= '0;
          col_q   <= 2'b00;
          blank_q <= 1'b1;
          sel_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sel        = sel_q;
  assign col        = col_q;
  assign blank      = blank_q;
  assign frame_tick = frame_tick_q;

  // ---------------- sensor conditioning ----------------
  logic [7:0]         sync1_q, sync2_q;
  logic [7:0]         ch_out_q;
  logic [7:0][DW-1:0] cnt_q;

  // Each bit counts consecutive cycles of disagreement with its accepted
  // value; any cycle of agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      ch_out_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= ch_in;
      sync2_q <= sync1_q;
      for (int i = 0; i < 8; i++) begin
        if (sync2_q[i] == ch_out_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DEB_END) begin
          ch_out_q[i] <= sync2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign ch_out = ch_out_q;

  // ---------------- free-spot count ----------------
  logic [3:0] ones_d;
  logic [3:0] vagas_d;
  logic [3:0] vagas_q;
  logic       lotado_q;

  always_comb begin
    ones_d = '0;
    for (int i = 0; i < 8; i++) ones_d = ones_d + {3'b000, ch_out_q[i]};
    vagas_d = 4'd8 - ones_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vagas_q  <= 4'd8;
      lotado_q <= 1'b0;
    end else begin
      vagas_q  <= vagas_d;
      lotado_q <= (vagas_d == 4'd0);
    end
  end

  assign vagas_livres = vagas_q;
  assign lotado       = lotado_q;

endmodule

// File: tb/tb_varredura_matriz.sv
module tb_varredura_matriz;

  localparam int DIV = 4;
  localparam int BLANK = 2;
  localparam int DEB = 3;
  localparam int P = 2 * (DIV + BLANK);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ch_in = '0;
  logic [7:0] ch_out;
  logic       sel;
  logic [1:0] col;
  logic       blank;
  logic       frame_tick;
  logic [3:0] vagas_livres;
  logic       lotado;

  int checks = 0;
  int errors = 0;

  varredura_matriz #(.DIV(DIV), .BLANK(BLANK), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .ch_in(ch_in), .ch_out(ch_out), .sel(sel),
    .col(col), .blank(blank), .frame_tick(frame_tick),
    .vagas_livres(vagas_livres), .lotado(lotado)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // k = rising edges since reset release. Sensor value seen by the debounce
  // logic at edge k is ch_in as applied before edge k-2. A bit flips when the
  // last DEB seen values all disagree with the accepted value.
  int         k;
  logic [7:0] in_hist [0:4095];
  logic [7:0] s_hist  [0:4095];
  logic [7:0] out_exp;
  logic [3:0] vag_exp;
  logic       lot_exp;
  logic [1:0] col_exp;
  logic       sel_exp, ft_exp, blank_exp;

  function automatic logic [3:0] scan_at(input int c);
    int m;
    if (c < BLANK) return 4'b0000;
    m = (c - BLANK) % P;
    if (m < DIV)              return {(m == 0), 1'b0, 2'b01};
    if (m < DIV + BLANK)      return 4'b0100;
    if (m < 2 * DIV + BLANK)  return 4'b0110;
    return 4'b0000;
  endfunction

  task automatic model_scan();
    {ft_exp, sel_exp, col_exp} = scan_at(k);
    blank_exp = (col_exp == 2'b00);
  endtask

  task automatic model_reset();
    k = 0;
    out_exp = '0;
    vag_exp = 4'd8;
    lot_exp = 1'b0;
    model_scan();
  endtask

  task automatic model_edge();
    logic [7:0] s, nxt;
    bit all;
    s = (k >= 2) ? in_hist[k-2] : 8'h00;
    s_hist[k] = s;
    vag_exp = 4'(8 - $countones(out_exp));
    lot_exp = (vag_exp == 4'd0);
    nxt = out_exp;
    if (k >= DEB - 1) begin
      for (int i = 0; i < 8; i++) begin
        all = 1;
        for (int j = 0; j < DEB; j++)
          if (s_hist[k-j][i] == out_exp[i]) all = 0;
        if (all) nxt[i] = ~out_exp[i];
      end
    end
    out_exp = nxt;
    k++;
    model_scan();
  endtask

  // Apply din before the next edge, advance model and DUT, land on negedge.
  task automatic tick(input logic [7:0] din);
    in_hist[k] = din;
    ch_in = din;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    ch_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    ch_in = 8'hA5;
    repeat (2) @(negedge clk);
    checks++;
    if ({col, sel, blank, frame_tick} !== 5'b00010 || ch_out !== 8'h00 ||
        vagas_livres !== 4'd8 || lotado !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: col=%b sel=%b blank=%b ft=%b ch_out=%h vagas=%0d lotado=%b, want 00 0 1 0 00 8 0",
               col, sel, blank, frame_tick, ch_out, vagas_livres, lotado);
    end
    release_reset();
  endtask

  task automatic test_scan(input string tag);
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) tick(8'h00);
      checks++;
      if (col !== col_exp || sel !== sel_exp || frame_tick !== ft_exp || blank !== blank_exp) begin
        errors++;
        $display("FAIL %s_cycle%0d: col=%b sel=%b ft=%b blank=%b, want %b %b %b %b",
                 tag, c, col, sel, frame_tick, blank, col_exp, sel_exp, ft_exp, blank_exp);
      end
      if (c == 2 || c == 14) begin
        checks++;
        if (frame_tick !== 1'b1 || col !== 2'b01) begin
          errors++;
          $display("FAIL %s_frame_start%0d: ft=%b col=%b, want 1 01", tag, c, frame_tick, col);
        end
      end
      if (c == 6 || c == 8 || c == 12) begin
        checks++;
        if ({sel, col} !== ((c == 6) ? 3'b100 : (c == 8) ? 3'b110 : 3'b000)) begin
          errors++;
          $display("FAIL %s_phase%0d: sel=%b col=%b", tag, c, sel, col);
        end
      end
    end
  endtask

  task automatic test_debounce();
    int lat;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      tick(8'h08);
      lat++;
      if (ch_out[3] === 1'b1) break;
    end
    checks++;
    if (lat != 2 + DEB || ch_out !== out_exp) begin
      errors++;
      $display("FAIL debounce_latency: got %0d cycles ch_out=%h, want %0d cycles ch_out=%h",
               lat, ch_out, 2 + DEB, out_exp);
    end
    checks++;
    if (vagas_livres !== 4'd8) begin
      errors++;
      $display("FAIL debounce_vagas_before: vagas=%0d, want 8", vagas_livres);
    end
    tick(8'h08);
    checks++;
    if (vagas_livres !== 4'd7 || lotado !== 1'b0) begin
      errors++;
      $display("FAIL debounce_vagas_after: vagas=%0d lotado=%b, want 7 0", vagas_livres, lotado);
    end
    repeat (8) tick(8'h00);
    checks++;
    if (ch_out !== 8'h00 || vagas_livres !== 4'd8) begin
      errors++;
      $display("FAIL debounce_release: ch_out=%h vagas=%0d, want 00 8", ch_out, vagas_livres);
    end
  endtask

  task automatic test_glitch();
    tick(8'h20);
    tick(8'h20);
    for (int n = 0; n < 10; n++) begin
      tick(8'h00);
      checks++;
      if (ch_out !== 8'h00 || vagas_livres !== 4'd8 || ch_out !== out_exp) begin
        errors++;
        $display("FAIL glitch_%0d: ch_out=%h vagas=%0d, want 00 8", n, ch_out, vagas_livres);
      end
    end
  endtask

  task automatic test_all_bits();
    for (int n = 0; n < 2 + DEB; n++) begin
      tick(8'hFF);
      checks++;
      if (ch_out !== ((n == 1 + DEB) ? 8'hFF : 8'h00)) begin
        errors++;
        $display("FAIL all_bits_edge%0d: ch_out=%h", n, ch_out);
      end
    end
    tick(8'hFF);
    checks++;
    if (vagas_livres !== 4'd0 || lotado !== 1'b1) begin
      errors++;
      $display("FAIL all_bits_full: vagas=%0d lotado=%b, want 0 1", vagas_livres, lotado);
    end
    repeat (2 + DEB + 1) tick(8'h00);
    checks++;
    if (ch_out !== 8'h00 || vagas_livres !== 4'd8 || lotado !== 1'b0) begin
      errors++;
      $display("FAIL all_bits_empty: ch_out=%h vagas=%0d lotado=%b, want 00 8 0",
               ch_out, vagas_livres, lotado);
    end
  endtask

  task automatic test_reset_midop();
    int n;
    n = 0;
    while (!(out_exp == 8'hFF && col_exp == 2'b10) && n < 200) begin
      tick(8'hFF);
      n++;
    end
    checks++;
    if (col !== 2'b10 || ch_out !== 8'hFF) begin
      errors++;
      $display("FAIL midop_setup: col=%b ch_out=%h, want 10 ff", col, ch_out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (col !== 2'b00 || sel !== 1'b0 || blank !== 1'b1 || ch_out !== 8'h00 ||
        vagas_livres !== 4'd8 || lotado !== 1'b0) begin
      errors++;
      $display("FAIL midop_async_reset: col=%b sel=%b blank=%b ch_out=%h vagas=%0d lotado=%b, want 00 0 1 00 8 0",
               col, sel, blank, ch_out, vagas_livres, lotado);
    end
    release_reset();
    test_scan("rescan");
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic       prev_sel;
    int         hold;
    v = '0;
    hold = 0;
    prev_sel = sel;
    for (int n = 0; n < 600; n++) begin
      if (hold == 0) begin
        v = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (v ^ (8'h01 << $urandom_range(0, 7)));
        hold = $urandom_range(1, 6);
      end
      hold--;
      tick(v);
      checks++;
      if (col !== col_exp || sel !== sel_exp || frame_tick !== ft_exp || blank !== blank_exp ||
          ch_out !== out_exp || vagas_livres !== vag_exp || lotado !== lot_exp) begin
        errors++;
        $display("FAIL random_%0d: col=%b sel=%b ft=%b blank=%b ch_out=%h vagas=%0d lotado=%b, want %b %b %b %b %h %0d %b",
                 n, col, sel, frame_tick, blank, ch_out, vagas_livres, lotado,
                 col_exp, sel_exp, ft_exp, blank_exp, out_exp, vag_exp, lot_exp);
      end
      checks++;
      if (col === 2'b11 || blank !== (col == 2'b00) || (sel !== prev_sel && col !== 2'b00)) begin
        errors++;
        $display("FAIL random_invariant_%0d: col=%b blank=%b sel=%b prev_sel=%b",
                 n, col, blank, sel, prev_sel);
      end
      prev_sel = sel;
    end
  endtask

  initial begin
    test_reset();
    test_scan("scan");
    test_debounce();
    test_glitch();
    test_all_bits();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/varredura_matriz.md
Name: varredura_matriz

Overview:
Front-end stage feeding the parking-spot column multiplexer and the 4x2 common-anode LED matrix.
- Conditions the 8 raw spot sensors: synchronises, debounces and presents them as ch_out[7:0] to the multiplexer's ch0..ch7 inputs.
- Generates the multiplexer column select, the column enables and the blanking interval that prevents ghosting.
- Maintains the count of free spots.

Parameters:
- DIV, 50000: clock cycles each column stays lit (>=1).
- BLANK, 500: clock cycles of blanking between columns (>=1).
- DEB_CYCLES, 250000: consecutive stable cycles required before a sensor change is accepted (>=1).

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- ch_in, input, 8: raw spot sensors, 1 = occupied; bit i maps to spot i (even = column 1, odd = column 2).
- ch_out, output, 8: debounced sensors, wired to the multiplexer ch0..ch7.
- sel, output, 1: multiplexer column select (0 = even spots, 1 = odd spots).
- col, output, 2: column enables, active-high; 01 = column 1, 10 = column 2, 00 = blanked.
- blank, output, 1: high while both columns are off.
- frame_tick, output, 1: one-cycle pulse at the start of each full scan frame.
- vagas_livres, output, 4: number of free spots, 0..8.
- lotado, output, 1: high when vagas_livres == 0.

Behaviour:
Reset (asynchronous, takes effect immediately, also mid-operation):
- State S_BLANK1, phase counter 0, sel=0, col=00, blank=1, frame_tick=0.
- ch_out=00000000, synchroniser flops 0, all debounce counters 0.
- vagas_livres=8, lotado=0.

Scan FSM, one phase counter, cleared on every state change:
- S_BLANK1 -> S_COL0 after BLANK cycles. On entry to S_COL0: frame_tick=1 for exactly one cycle, col=01, blank=0.
- S_COL0 -> S_BLANK0 after DIV cycles. On entry to S_BLANK0: col=00, blank=1, sel=1.
- S_BLANK0 -> S_COL1 after BLANK cycles. On entry to S_COL1: col=10, blank=0.
- S_COL1 -> S_BLANK1 after DIV cycles. On entry to S_BLANK1: col=00, blank=1, sel=0.
- sel changes only on entry to a blank state, so the multiplexer output settles before its column is enabled.
- col is never 11.
- Frame period = 2*(DIV+BLANK) cycles.
- All scan outputs are registered.

Debounce, independent per bit i:
- 2-flop synchroniser on ch_in[i] gives s[i].
- If s[i] == ch_out[i]: cnt[i] is held at 0.
- If s[i] != ch_out[i]: cnt[i] increments. When cnt[i] reaches DEB_CYCLES-1 and s[i] still differs, ch_out[i] <= s[i] on that edge and cnt[i] <= 0.
- Any glitch back to ch_out[i] before acceptance clears cnt[i]. Total latency from a stable ch_in change to ch_out = 2 + DEB_CYCLES cycles.
- Counter width = clog2(DEB_CYCLES)+1; no wrap-around is possible.
- Simultaneous changes on several bits are handled independently, and can update on the same edge.

Free-spot count:
- vagas_livres <= 8 - popcount(ch_out), registered; updates one cycle after ch_out changes.
- lotado is registered together with vagas_livres and is coherent with it on every cycle.
- ch_out is never affected by scan state, and the scan is never affected by ch_out.

Test Plan:
Run with DIV=4, BLANK=2, DEB_CYCLES=3.
1. Release reset, ch_in=0: col=00 for cycles 0-1; frame_tick pulse and col=01 at cycle 2; sel=1, col=00 at cycle 6; col=10 at cycle 8; sel=0, col=00 at cycle 12; next frame_tick at cycle 14 (period 12).
2. ch_in[3] 0->1 held steady: ch_out[3]=1 exactly 5 cycles later; vagas_livres 8->7 one cycle after that.
3. ch_in[5] pulse of 2 cycles: ch_out unchanged, vagas_livres stays 8.
4. ch_in 00000000->11111111 in one step: all bits update on the same edge; vagas_livres=0 and lotado=1 one cycle later. Return to 0: vagas_livres=8, lotado=0.
5. Assert reset while in S_COL1 with ch_out=0xFF: outputs immediately show col=00, sel=0, ch_out=0, vagas_livres=8. After release, sequence restarts as in scenario 1.
6. Full random run: col is never 11; sel never toggles while col != 00; blank == (col == 00) on every cycle.
